wvb_reader: RTL and testbench
=============================

# wvb_reader

Waveform-buffer readout engine between the per-channel waveform buffers and the xdom direct-readout DPRAM. When enabled, it picks the next channel holding a complete waveform (round-robin). It copies that waveform's header and samples into the DPRAM as one 32-bit-word record, then hands the record to xdom with a one-cycle `dpram_run` pulse. In discard mode it pops waveforms without writing anything, which drains the buffers.

## Interface
- `N_CHANNELS`, 24, number of waveform buffers (2..32)
- `MAX_SAMPLES`, 2042, sample cap per record; 3 + 2042/2 = 1024 words fills the 1024-word DPRAM
- `clk`  in  1  system clock; the block has one clock
- `rst`  in  1  reset, asynchronous, active-high
- `enable`  in  1  `wvb_reader_enable` from xdom; gates the start of new events only
- `dpram_mode`  in  1  1 = write records to the DPRAM; 0 = discard events
- `dpram_busy`  in  1  from xdom; high while a record is owned by software
- `hdr_not_empty`  in  N_CHANNELS  per-channel header FIFO non-empty
- `hdr_data`  in  N_CHANNELS*72  per-channel show-ahead header, `{ltc[47:0], start_addr[11:0], stop_addr[11:0]}`; channel c is at bits [72c+71:72c]
- `hdr_rdreq`  out  N_CHANNELS  one-cycle pop of a channel's header FIFO
- `wvb_rd_addr`  out  12  sample address, shared by all channels
- `wvb_rd_data`  in  N_CHANNELS*16  per-channel sample RAM output; 2-cycle read latency
- `dpram_wren`  out  1  DPRAM write strobe
- `dpram_wr_addr`  out  10  DPRAM word address
- `dpram_data`  out  32  DPRAM write data
- `dpram_len`  out  16  record length in 32-bit words; valid with `dpram_run`
- `dpram_run`  out  1  one-cycle pulse: a record is complete

## Operation
- **Reset.** All outputs are 0 and the state is IDLE. The round-robin pointer `last` is N_CHANNELS-1, so channel 0 wins the first search.
- **Channel grant.** The grant is the lowest-index channel in the rotating order last+1, …, N-1, 0, …, last with `hdr_not_empty` set. The search is combinational and completes in one cycle. `last` updates to the granted channel.
- **IDLE → LATCH.** Taken when `enable` is high, any `hdr_not_empty` bit is set, and either `dpram_mode` is 0 or `dpram_busy` is 0. LATCH registers the granted channel `ch`, the header fields, and `dpram_mode` (the mode is frozen for the whole event).
- **Sample count.** n = ((stop_addr - start_addr) mod 4096) + 1, so 1..4096; the address wraps when stop < start. If n > MAX_SAMPLES, the record keeps only the first MAX_SAMPLES samples (ns = MAX_SAMPLES) and sets trunc = 1; otherwise ns = n and trunc = 0.
- **Discard mode.** From LATCH go to POP and issue `hdr_rdreq[ch]`. Nothing is written to the DPRAM and `dpram_run` does not pulse.
- **DPRAM mode — header words.** State HDR writes three words at addresses 0, 1, 2:
  - word 0 = `{8'hA5, trunc, 2'b0, ch[4:0], ns[15:0]}`
  - word 1 = `ltc[47:16]`
  - word 2 = `{ltc[15:0], 4'b0, start_addr}`
- **DPRAM mode — sample read and write.**
  - RD issues sample addresses start_addr, start_addr+1, … (mod 4096), one per cycle, ns addresses total.
  - Returned samples come from `wvb_rd_data[ch]`.
  - Samples are paired and written as `{sample[2k+1], sample[2k]}` to addresses 3, 4, …
  - If ns is odd, the last word is `{16'h0000, sample[ns-1]}`.
  - DRAIN waits for the read pipeline to empty.
- **POP, RUN, WAIT_ACK.** POP pulses `hdr_rdreq[ch]` and `dpram_len` = 3 + ceil(ns/2). RUN pulses `dpram_run`. WAIT_ACK holds until `dpram_busy` = 1, then returns to IDLE.
- **Disable mid-event.** Deasserting `enable` during an event lets that event finish normally; it only blocks the next one.
- **Reset mid-event.** Reset aborts immediately: no pop is issued, the header stays in its FIFO, and the state returns to IDLE.

## Timing
- IDLE→LATCH takes 1 cycle. The HDR state writes occupy 3 consecutive cycles.
- An address issued in cycle t returns data in cycle t+2. A word is written in the cycle its second sample arrives, or, for odd ns, the cycle after the last sample arrives.
- Total latency from LATCH to `dpram_run` is 3 + ns + 2 + 2 cycles, ±1 for odd ns. The implementation must match this count exactly; the bench checks it.
- `dpram_wren` is high only in the cycles a word is written; `dpram_wr_addr` increments by exactly 1 per write.
- `hdr_rdreq` is a single cycle per event, always one-hot.
- `dpram_run` fires exactly one cycle after the pop.
- Back-to-back events in discard mode cost 3 cycles each (IDLE, LATCH, POP).

## Test plan
- **Basic record.** ch 5, start=0x010, stop=0x013, ltc=0x123456789ABC → words A5_05_0004, 12345678, 9ABC_0010, {s1,s0}, {s3,s2}; `dpram_len` = 5; one `dpram_run` pulse; one pulse on `hdr_rdreq[5]`.
- **Odd count with address wrap.** start=0xFFE, stop=0x000 → ns = 3; addresses FFE, FFF, 000; last word upper half 0; `dpram_len` = 5.
- **Truncation.** start=0, stop=0xFFF → ns = 2042, trunc bit (word 0 bit 23) = 1, `dpram_len` = 1024, final write at address 1023.
- **Round-robin order.** Channels 2, 7, and 23 all non-empty, `last` = 7, discard mode → service order 23, 2, 7, 23… with 3 cycles per event and no DPRAM writes.
- **Busy handshake.** Hold `dpram_busy` = 1 after the first `dpram_run` → no second LATCH until busy returns to 0; deasserting `enable` mid-event still completes the record.
- **Reset mid-event.** Assert `rst` during RD → all outputs 0 asynchronously, no `hdr_rdreq`; after release the same channel is served again with an identical record.

Source files
------------

// File: rtl/wvb_reader.sv
// Waveform-buffer readout engine: round-robin channel pick, header and
// sample copy into the xdom DPRAM, or silent discard of waveforms.
module wvb_reader #(
  parameter int N_CHANNELS  = 24,
  parameter int MAX_SAMPLES = 2042
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     dpram_mode,
  input  logic                     dpram_busy,
  input  logic [N_CHANNELS-1:0]    hdr_not_empty,
  input  logic [N_CHANNELS*72-1:0] hdr_data,
  output logic [N_CHANNELS-1:0]    hdr_rdreq,
  output logic [11:0]              wvb_rd_addr,
  input  logic [N_CHANNELS*16-1:0] wvb_rd_data,
  output logic                     dpram_wren,
  output logic [9:0]               dpram_wr_addr,
  output logic [31:0]              dpram_data,
  output logic [15:0]              dpram_len,
  output logic                     dpram_run
);

  typedef enum logic [2:0] {
    IDLE, LATCH, HDR, RD, DRAIN, POP, RUN, WAIT_ACK
  } state_t;

  state_t state;

  logic [4:0]  ch;
  logic [4:0]  last;
  logic [4:0]  grant;
  logic        any;
  logic [71:0] hsel;
  logic [47:0] ltc;
  logic [11:0] start;
  logic [11:0] stop;
  logic        mode;
  logic [12:0] n_c;
  logic [12:0] ns_c;
  logic [12:0] ns_q;
  logic        trunc_c;
  logic [1:0]  hidx;
  logic [12:0] icnt;
  logic [12:0] rcv;
  logic        hi;
  logic        v1;
  logic        v2;
  logic        wr_q;
  logic [15:0] lo_q;
  logic [15:0] sample;
  logic [31:0] wdata_q;
  logic [9:0]  wa;
  logic [15:0] len_c;
  logic        pair_we;
  logic [N_CHANNELS-1:0] onehot;

  // Rotating-priority grant: lowest channel above last, else lowest overall
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int j = N_CHANNELS - 1; j >= 0; j--) begin
      if (hdr_not_empty[j]) begin
        any   = 1'b1;
        grant = 5'(j);
      end
    end
    for (int j = N_CHANNELS - 1; j >= 0; j--) begin
      if (hdr_not_empty[j] && j > int'(last)) grant = 5'(j);
    end
  end

  assign hsel    = hdr_data[72*grant +: 72];
  assign sample  = wvb_rd_data[16*ch +: 16];
  assign n_c     = {1'b0, stop - start} + 13'd1;
  assign trunc_c = n_c > 13'(MAX_SAMPLES);
  assign ns_c    = trunc_c ? 13'(MAX_SAMPLES) : n_c;
  assign len_c   = 16'd3 + {4'b0, ns_q[12:1]} + {15'b0, ns_q[0]};
  assign onehot  = {{(N_CHANNELS-1){1'b0}}, 1'b1} << ch;

  // A sample pair is written in the cycle its upper half arrives
  assign pair_we       = v2 & hi;
  assign dpram_wren    = wr_q | pair_we;
  assign dpram_data    = pair_we ? {sample, lo_q} : wdata_q;
  assign dpram_wr_addr = wa;

  // Event sequencer, read pipeline tracking and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      last        <= 5'(N_CHANNELS - 1);
      ltc         <= '0;
      start       <= '0;
      stop        <= '0;
      mode        <= 1'b0;
      ns_q        <= '0;
      hidx        <= '0;
      icnt        <= '0;
      rcv         <= '0;
      hi          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      wr_q        <= 1'b0;
      lo_q        <= '0;
      wdata_q     <= '0;
      wa          <= '0;
      hdr_rdreq   <= '0;
      wvb_rd_addr <= '0;
      dpram_len   <= '0;
      dpram_run   <= 1'b0;
    end else begin
      hdr_rdreq <= '0;
      dpram_run <= 1'b0;
      wr_q      <= 1'b0;
      v1        <= (state == RD);
      v2        <= v1;
      if (dpram_wren) wa <= wa + 10'd1;
      if (v2) begin
        rcv <= rcv + 13'd1;
        if (!hi) begin
          lo_q <= sample;
          hi   <= 1'b1;
          if (rcv == ns_q - 13'd1) begin
            wr_q    <= 1'b1;
            wdata_q <= {16'h0000, sample};
          end
        end else begin
          hi <= 1'b0;
        end
      end
      unique case (state)
        IDLE: begin
          if (enable && any && (!dpram_mode || !dpram_busy)) begin
            state               <= LATCH;
            ch                  <= grant;
            last                <= grant;
            {ltc, start, stop}  <= hsel;
            mode                <= dpram_mode;
          end
        end
        LATCH: begin
          ns_q <= ns_c;
          wa   <= '0;
          rcv  <= '0;
          hi   <= 1'b0;
          hidx <= '0;
          if (mode) begin
            state   <= HDR;
            wr_q    <= 1'b1;
            wdata_q <= {8'hA5, trunc_c, 2'b00, ch, 3'b000, ns_c};
          end else begin
            state     <= POP;
            hdr_rdreq <= onehot;
          end
        end
        HDR: begin
          hidx <= hidx + 2'd1;
          if (hidx == 2'd0) begin
            wr_q    <= 1'b1;
            wdata_q <= ltc[47:16];
          end else if (hidx == 2'd1) begin
            wr_q    <= 1'b1;
            wdata_q <= {ltc[15:0], 4'h0, start};
          end else begin
            state       <= RD;
            wvb_rd_addr <= start;
            icnt        <= '0;
          end
        end
        RD: begin
          if (icnt == ns_q - 13'd1) begin
            state <= DRAIN;
          end else begin
            wvb_rd_addr <= wvb_rd_addr + 12'd1;
            icnt        <= icnt + 13'd1;
          end
        end
        DRAIN: begin
          if (!v1 && !(v2 && ns_q[0])) begin
            state     <= POP;
            hdr_rdreq <= onehot;
            dpram_len <= len_c;
          end
        end
        POP: begin
          if (mode) begin
            state     <= RUN;
            dpram_run <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: state <= WAIT_ACK;
        WAIT_ACK: if (dpram_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Directed and randomized bench for wvb_reader with a FIFO/RAM model
// and a record-level reference computed from the header rules.
module tb_wvb_reader;

  localparam int N  = 24;
  localparam int MS = 2042;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           dpram_mode = 1'b0;
  logic           dpram_busy = 1'b0;
  logic [N-1:0]   hdr_not_empty;
  logic [N*72-1:0] hdr_data;
  logic [N-1:0]   hdr_rdreq;
  logic [11:0]    wvb_rd_addr;
  logic [N*16-1:0] wvb_rd_data;
  logic           dpram_wren;
  logic [9:0]     dpram_wr_addr;
  logic [31:0]    dpram_data;
  logic [15:0]    dpram_len;
  logic           dpram_run;

  wvb_reader #(.N_CHANNELS(N), .MAX_SAMPLES(MS)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .dpram_mode(dpram_mode), .dpram_busy(dpram_busy),
    .hdr_not_empty(hdr_not_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr),
    .wvb_rd_data(wvb_rd_data), .dpram_wren(dpram_wren),
    .dpram_wr_addr(dpram_wr_addr), .dpram_data(dpram_data),
    .dpram_len(dpram_len), .dpram_run(dpram_run)
  );

  always #5 clk = ~clk;

  logic [15:0]    mem [N][4096];
  logic [71:0]    hf [N][16];
  int             hh [N];
  int             ht [N];
  logic [N*16-1:0] p1;

  always_comb begin
    hdr_not_empty = '0;
    hdr_data      = '0;
    for (int c = 0; c < N; c++) begin
      hdr_not_empty[c]   = (hh[c] != ht[c]);
      hdr_data[c*72 +: 72] = hf[c][4'(hh[c])];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      p1[c*16 +: 16] <= mem[c][wvb_rd_addr];
      if (hdr_rdreq[c] && hh[c] != ht[c]) hh[c] <= hh[c] + 1;
    end
    wvb_rd_data <= p1;
  end

  int cyc, nwr, nruns, npops, run_cyc, first_wr, pop_ch, pop_cyc;
  int addr_bad, hot_bad, last_addr;
  logic [31:0] dmem [1024];
  int popq[$];
  int popc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (dpram_wren) begin
        nwr <= nwr + 1;
        dmem[dpram_wr_addr] <= dpram_data;
        last_addr <= int'(dpram_wr_addr);
        if (dpram_wr_addr == 10'd0) first_wr <= cyc;
        else if (int'(dpram_wr_addr) != last_addr + 1) addr_bad <= addr_bad + 1;
      end
      if (dpram_run) begin
        nruns   <= nruns + 1;
        run_cyc <= cyc;
      end
      if (hdr_rdreq != '0) begin
        npops   <= npops + 1;
        pop_cyc <= cyc;
        if ($countones(hdr_rdreq) != 1) hot_bad <= hot_bad + 1;
        for (int c = 0; c < N; c++) begin
          if (hdr_rdreq[c]) begin
            pop_ch <= c;
            popq.push_back(c);
            popc.push_back(cyc);
          end
        end
      end
    end
  end

  int checks, errors;
  logic [31:0] ew [1024];
  int ewn, ens;
  logic etr;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [71:0] h);
    hf[c][4'(ht[c])] = h;
    ht[c] = ht[c] + 1;
  endtask

  task automatic model(input int c, input logic [71:0] h);
    logic [47:0] l;
    logic [11:0] s, e, d, a;
    int n;
    {l, s, e} = h;
    d = e - s;
    n = int'(d) + 1;
    etr = (n > MS);
    ens = etr ? MS : n;
    ew[0] = {8'hA5, etr, 2'b00, 5'(c), 16'(ens)};
    ew[1] = l[47:16];
    ew[2] = {l[15:0], 4'h0, s};
    for (int k = 0; k < ens; k++) begin
      a = s + 12'(k);
      if (k % 2 == 0) ew[3 + k/2] = {16'h0000, mem[c][a]};
      else ew[3 + k/2][31:16] = mem[c][a];
    end
    ewn = 3 + (ens + 1) / 2;
  endtask

  task automatic wait_run(input string tag);
    int t;
    t = 0;
    while (!dpram_run && t < 6000) begin
      tick();
      t++;
    end
    chk({tag, " run_seen"}, 64'(dpram_run), 64'd1);
  endtask

  task automatic check_record(input int c, input logic [71:0] h,
                              input int n0, input int r0, input int p0,
                              input string tag);
    int bad;
    model(c, h);
    chk({tag, " len"}, 64'(dpram_len), 64'(ewn));
    chk({tag, " nwords"}, 64'(nwr - n0), 64'(ewn));
    chk({tag, " word0"}, 64'(dmem[0]), 64'(ew[0]));
    bad = 0;
    for (int i = 0; i < ewn; i++) if (dmem[i] !== ew[i]) bad++;
    chk({tag, " word_errs"}, 64'(bad), 64'd0);
    chk({tag, " latency"}, 64'(run_cyc - first_wr), 64'(6 + ens + ens % 2));
    chk({tag, " npops"}, 64'(npops - p0), 64'd1);
    chk({tag, " pop_ch"}, 64'(pop_ch), 64'(c));
    chk({tag, " pop_to_run"}, 64'(run_cyc - pop_cyc), 64'd1);
    tick();
    chk({tag, " run_one_cycle"}, 64'(dpram_run), 64'd0);
    chk({tag, " nruns"}, 64'(nruns - r0), 64'd1);
  endtask

  task automatic rec(input int c, input logic [71:0] h, input string tag);
    int n0, r0, p0;
    n0 = nwr;
    r0 = nruns;
    p0 = npops;
    push(c, h);
    wait_run(tag);
    check_record(c, h, n0, r0, p0, tag);
  endtask

  task automatic ack();
    dpram_busy = 1'b1;
    tick();
    tick();
    dpram_busy = 1'b0;
    tick();
  endtask

  initial begin
    logic [71:0] h, hb;
    logic [11:0] s;
    int c, n0, r0, p0, t, base, bad, bad2, lst;
    int cnt [N];
    int expc;

    for (int cc = 0; cc < N; cc++)
      for (int a = 0; a < 4096; a++) mem[cc][a] = 16'($urandom);

    tick();
    tick();
    chk("reset_outputs",
        64'({hdr_rdreq, wvb_rd_addr, dpram_wren, dpram_wr_addr,
             dpram_data, dpram_len, dpram_run}), 64'd0);
    rst = 1'b0;
    tick();

    dpram_mode = 1'b1;
    enable = 1'b1;
    h = {48'h123456789ABC, 12'h010, 12'h013};
    rec(5, h, "basic");
    chk("basic w0", 64'(dmem[0]), 64'h00000000A5050004);
    chk("basic w1", 64'(dmem[1]), 64'h0000000012345678);
    chk("basic w2", 64'(dmem[2]), 64'h000000009ABC0010);
    chk("basic len", 64'(dpram_len), 64'd5);
    ack();

    c = int'($urandom_range(0, N - 1));
    h = {48'(({$urandom, $urandom})), 12'hFFE, 12'h000};
    rec(c, h, "wrap");
    chk("wrap len", 64'(dpram_len), 64'd5);
    chk("wrap upper0", 64'(dmem[4][31:16]), 64'd0);
    ack();

    c = int'($urandom_range(0, N - 1));
    h = {48'(({$urandom, $urandom})), 12'h000, 12'hFFF};
    rec(c, h, "trunc");
    chk("trunc bit", 64'(dmem[0][23]), 64'd1);
    chk("trunc len", 64'(dpram_len), 64'd1024);
    chk("trunc last_addr", 64'(last_addr), 64'd1023);
    ack();

    for (int i = 0; i < 6; i++) begin
      c = int'($urandom_range(0, N - 1));
      s = 12'($urandom);
      h = {48'(({$urandom, $urandom})), s,
           s + 12'((i == 0) ? 0 : $urandom_range(1, 40))};
      rec(c, h, $sformatf("rand%0d", i));
      ack();
    end

    dpram_mode = 1'b0;
    p0 = npops;
    push(7, 72'($urandom));
    t = 0;
    while (npops == p0 && t < 50) begin
      tick();
      t++;
    end
    chk("rr prime ch", 64'(pop_ch), 64'd7);
    enable = 1'b0;
    tick();
    tick();
    foreach (cnt[i]) cnt[i] = 0;
    for (int k = 0; k < 2; k++) begin
      push(2, 72'($urandom));
      push(7, 72'($urandom));
      push(23, 72'($urandom));
    end
    cnt[2] = 2;
    cnt[7] = 2;
    cnt[23] = 2;
    base = popq.size();
    n0 = nwr;
    r0 = nruns;
    enable = 1'b1;
    t = 0;
    while (popq.size() < base + 6 && t < 200) begin
      tick();
      t++;
    end
    chk("rr npops", 64'(popq.size() - base), 64'd6);
    lst = 7;
    bad = 0;
    bad2 = 0;
    for (int e = 0; e < 6; e++) begin
      expc = -1;
      for (int i = 1; i <= N && expc < 0; i++)
        if (cnt[(lst + i) % N] > 0) expc = (lst + i) % N;
      cnt[expc]--;
      lst = expc;
      if (popq.size() > base + e && popq[base + e] != expc) bad++;
      if (e > 0 && popc.size() > base + e &&
          popc[base + e] - popc[base + e - 1] != 3) bad2++;
    end
    chk("rr order_errs", 64'(bad), 64'd0);
    chk("rr spacing_errs", 64'(bad2), 64'd0);
    chk("rr no_writes", 64'(nwr - n0), 64'd0);
    chk("rr no_runs", 64'(nruns - r0), 64'd0);

    dpram_mode = 1'b1;
    tick();
    h = {48'(({$urandom, $urandom})), 12'h100, 12'h107};
    rec(3, h, "busyA");
    dpram_busy = 1'b1;
    hb = {48'(({$urandom, $urandom})), 12'h200, 12'h20C};
    push(4, hb);
    n0 = nwr;
    r0 = nruns;
    p0 = npops;
    repeat (20) tick();
    chk("busy no_write", 64'(nwr - n0), 64'd0);
    chk("busy no_pop", 64'(npops - p0), 64'd0);
    dpram_busy = 1'b0;
    t = 0;
    while (nwr == n0 && t < 20) begin
      tick();
      t++;
    end
    enable = 1'b0;
    wait_run("busyB");
    check_record(4, hb, n0, r0, p0, "busyB");
    enable = 1'b1;
    ack();

    s = 12'($urandom);
    h = {48'(({$urandom, $urandom})), s, s + 12'd19};
    n0 = nwr;
    p0 = npops;
    push(9, h);
    t = 0;
    while (nwr - n0 < 3 && t < 100) begin
      tick();
      t++;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst async_outputs",
        64'({hdr_rdreq, wvb_rd_addr, dpram_wren, dpram_wr_addr,
             dpram_data, dpram_len, dpram_run}), 64'd0);
    tick();
    tick();
    chk("rst no_pop", 64'(npops - p0), 64'd0);
    rst = 1'b0;
    tick();
    n0 = nwr;
    r0 = nruns;
    p0 = npops;
    wait_run("rst_replay");
    check_record(9, h, n0, r0, p0, "rst_replay");
    ack();

    chk("wr_addr_step_errs", 64'(addr_bad), 64'd0);
    chk("rdreq_onehot_errs", 64'(hot_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
